dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single data memory between the CPU load/store unit (port 0) and the debug/program loader (port 1). It serialises requests with a req/ack handshake, grants ties round-robin, checks sub-word alignment, and drives the memory's chip-enable, write-enable, read-enable and mask inputs for exactly one cycle per access. The block sits between the two requesters and the data memory, so the memory only ever sees one access at a time.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_arbiter_rr_arb2.sv | 14 +
 rtl/dmem_arbiter.sv | 158 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared state encodings, mask constants and the alignment rule for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  // Byte accesses are always aligned; any mask that is not byte or half is a word.
  function automatic logic is_misaligned(input logic [3:0] mask, input logic [1:0] addr_lo);
    logic mis;
    if (mask == MASK_B) begin
      mis = 1'b0;
    end else if (mask == MASK_H) begin
      mis = addr_lo[0];
    end else begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; on a tie the port that did not win last time is chosen.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant_valid,
  output logic       grant_idx
);

  assign grant_valid = |req;
  assign grant_idx   = (req == 2'b11) ? ~last : req[1];

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises two req/ack ports onto one data memory: grant in IDLE, one-cycle ACCESS, ack in DONE.
// Request seen at cycle N -> memory access in N+1, ack in N+2; next grant no earlier than N+3.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [3:0]        mask0,
  input  logic [3:0]        mask1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_w_mask,
  output logic [3:0]        mem_r_mask,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        mask;
    logic              idx;
    logic              err;
  } lat_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  lat_t              lat_q, lat_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_rd_q, mem_rd_d;

  logic              grant_valid;
  logic              grant_idx;

  rr_arb2 u_rr_arb2 (
    .req         ({req1, req0}),
    .last        (last_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    lat_d    = lat_q;
    ack_d    = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    mem_ce_d = 1'b0;
    mem_we_d = 1'b0;
    mem_rd_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          lat_d.we    = grant_idx ? we1    : we0;
          lat_d.addr  = grant_idx ? addr1  : addr0;
          lat_d.wdata = grant_idx ? wdata1 : wdata0;
          lat_d.mask  = grant_idx ? mask1  : mask0;
          lat_d.idx   = grant_idx;
          // Evaluated on the payload being latched so the ACCESS-cycle controls can be registered.
          lat_d.err   = is_misaligned(lat_d.mask, lat_d.addr[1:0]);
          last_d      = grant_idx;
          mem_ce_d    = ~lat_d.err;
          mem_we_d    = ~lat_d.err & lat_d.we;
          mem_rd_d    = ~lat_d.err & ~lat_d.we;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ack_d[lat_q.idx] = 1'b1;
        err_d[lat_q.idx] = lat_q.err;
        if (!lat_q.we && !lat_q.err) begin
          if (lat_q.idx) begin
            rdata1_d = mem_rdata;
          end else begin
            rdata0_d = mem_rdata;
          end
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      lat_q    <= '0;
      ack_q    <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
      mem_ce_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      lat_q    <= lat_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      mem_ce_q <= mem_ce_d;
      mem_we_q <= mem_we_d;
      mem_rd_q <= mem_rd_d;
    end
  end

  assign ack0       = ack_q[0];
  assign ack1       = ack_q[1];
  assign err0       = err_q[0];
  assign err1       = err_q[1];
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;
  assign mem_ce     = mem_ce_q;
  // A reset landing on the ACCESS cycle must not let the store commit at that edge.
  assign mem_we     = mem_we_q & ~rst;
  assign mem_rd     = mem_rd_q;
  assign mem_addr   = lat_q.addr;
  assign mem_wdata  = lat_q.wdata;
  assign mem_w_mask = lat_q.mask;
  assign mem_r_mask = lat_q.mask;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked every cycle against a
// transaction-level model (grant/ack timing from cycle arithmetic, byte-array memory image).
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [3:0]    mask0, mask1;
  logic          ack0, ack1, err0, err1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_ce, mem_we, mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_w_mask, mem_r_mask;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .mask0(mask0), .mask1(mask1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_w_mask(mem_w_mask), .mem_r_mask(mem_r_mask),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Environment memory: byte addressed on addr[7:0], right-aligned data, per-byte masks.
  logic [7:0] em [256] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_ce && mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_w_mask[i]) em[8'(mem_addr[7:0] + i)] <= mem_wdata[8*i +: 8];
  end
  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 4; i++)
      if (mem_r_mask[i]) mem_rdata[8*i +: 8] = em[8'(mem_addr[7:0] + i)];
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    mask;
    int            gap;
  } tx_t;

  tx_t q0[$];
  tx_t q1[$];
  tx_t cur [2];
  bit  busy [2];
  int  wait_cnt [2];
  int  present_cyc [2];
  int  last_lat [2];

  // Reference model state
  logic [7:0]  mm [256];
  int          t;
  bit          g_active;
  int          g_cycle, g_port, free_at, last;
  tx_t         g_tx;
  bit          g_err;
  logic [31:0] exp_rd [2];
  bit          rd_known [2];
  bit          rst_prev;

  // Observation records
  int          ack_order[$];
  int          ack_cyc[$];
  int          ce_cnt;
  int          err_cnt [2];
  logic [3:0]  last_wm, last_rm;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, t);
    end
  endtask

  function automatic bit model_err(input logic [3:0] m, input logic [AW-1:0] a);
    if (m == 4'b0001) return 1'b0;
    if (m == 4'b0011) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [AW-1:0] a, input logic [3:0] m);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      if (m[i]) v[8*i +: 8] = mm[8'(a[7:0] + i)];
    return v;
  endfunction

  function automatic tx_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [3:0] m);
    tx_t x;
    x.we = w; x.addr = a; x.wdata = d; x.mask = m; x.gap = 0;
    return x;
  endfunction

  function automatic tx_t rand_tx();
    tx_t x;
    int  k;
    x.we    = 1'($urandom_range(0, 1));
    k       = $urandom_range(0, 8);
    x.mask  = (k < 3) ? 4'b0001 : (k < 6) ? 4'b0011 : 4'b1111;
    x.addr  = AW'($urandom_range(0, 255));
    if ($urandom_range(0, 3) != 0) x.addr[1:0] = 2'b00;
    x.wdata = $urandom;
    x.gap   = $urandom_range(0, 3);
    return x;
  endfunction

  task automatic drive_port(input int p, input bit obs_ack);
    tx_t nx;
    bit  have;
    if (rst_prev) busy[p] = 1'b0;
    if (busy[p] && obs_ack) begin
      busy[p]     = 1'b0;
      last_lat[p] = t - present_cyc[p];
    end
    if (!busy[p]) begin
      have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) begin
        nx = (p == 0) ? q0[0] : q1[0];
        if (wait_cnt[p] < nx.gap) begin
          wait_cnt[p]++;
        end else begin
          if (p == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          wait_cnt[p]    = 0;
          cur[p]         = nx;
          busy[p]        = 1'b1;
          present_cyc[p] = t;
        end
      end
    end
    if (p == 0) begin
      req0 = busy[0]; we0 = cur[0].we; addr0 = cur[0].addr; wdata0 = cur[0].wdata; mask0 = cur[0].mask;
    end else begin
      req1 = busy[1]; we1 = cur[1].we; addr1 = cur[1].addr; wdata1 = cur[1].wdata; mask1 = cur[1].mask;
    end
  endtask

  task automatic cycle(input bit r);
    bit a0, a1, acc, don;
    int w;
    @(negedge clk);
    a0 = ack0;
    a1 = ack1;
    drive_port(0, a0);
    drive_port(1, a1);
    rst = r;
    #1;
    if (rst_prev) begin
      chk("rst_ctl", 32'({ack0, ack1, err0, err1, mem_ce, mem_we, mem_rd, mem_w_mask, mem_r_mask}), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
    end
    acc = g_active && (t == g_cycle + 1);
    don = g_active && (t == g_cycle + 2);
    chk("ack0", 32'(ack0), 32'(don && g_port == 0));
    chk("ack1", 32'(ack1), 32'(don && g_port == 1));
    chk("err0", 32'(err0), 32'(don && g_port == 0 && g_err));
    chk("err1", 32'(err1), 32'(don && g_port == 1 && g_err));
    chk("mem_we", 32'(mem_we), 32'(acc && !g_err && g_tx.we && !r));
    if (!r) begin
      chk("mem_ce", 32'(mem_ce), 32'(acc && !g_err));
      chk("mem_rd", 32'(mem_rd), 32'(acc && !g_err && !g_tx.we));
    end
    if (acc && !g_err) begin
      chk("mem_addr", mem_addr, g_tx.addr);
      chk("mem_wdata", mem_wdata, g_tx.wdata);
      chk("mem_masks", 32'({mem_w_mask, mem_r_mask}), 32'({g_tx.mask, g_tx.mask}));
    end
    if (rd_known[0]) chk("rdata0", rdata0, exp_rd[0]);
    if (rd_known[1]) chk("rdata1", rdata1, exp_rd[1]);

    if (ack0 === 1'b1) begin ack_order.push_back(0); ack_cyc.push_back(t); end
    if (ack1 === 1'b1) begin ack_order.push_back(1); ack_cyc.push_back(t); end
    if (err0 === 1'b1) err_cnt[0]++;
    if (err1 === 1'b1) err_cnt[1]++;
    if (mem_ce === 1'b1) ce_cnt++;
    if (mem_ce === 1'b1 && mem_we === 1'b1) last_wm = mem_w_mask;
    if (mem_ce === 1'b1 && mem_rd === 1'b1) last_rm = mem_r_mask;

    if (r) begin
      g_active = 1'b0; last = 1; free_at = t + 1;
      exp_rd[0] = '0; exp_rd[1] = '0; rd_known[0] = 1'b1; rd_known[1] = 1'b1;
    end else begin
      if (acc && !g_err) begin
        if (g_tx.we) begin
          for (int i = 0; i < 4; i++)
            if (g_tx.mask[i]) mm[8'(g_tx.addr[7:0] + i)] = g_tx.wdata[8*i +: 8];
        end else begin
          exp_rd[g_port]   = model_load(g_tx.addr, g_tx.mask);
          rd_known[g_port] = 1'b1;
        end
      end else if (acc && !g_tx.we) begin
        rd_known[g_port] = 1'b0;
      end
      if (don) g_active = 1'b0;
      if (t >= free_at && (req0 || req1)) begin
        if (req0 && req1) w = 1 - last; else w = req1 ? 1 : 0;
        last        = w;
        g_active    = 1'b1;
        g_cycle     = t;
        g_port      = w;
        free_at     = t + 3;
        g_tx.we     = w ? we1 : we0;
        g_tx.addr   = w ? addr1 : addr0;
        g_tx.wdata  = w ? wdata1 : wdata0;
        g_tx.mask   = w ? mask1 : mask0;
        g_err       = model_err(g_tx.mask, g_tx.addr);
      end
    end
    rst_prev = r;
    t++;
  endtask

  task automatic run_until_idle(input int maxc, input bit rnd_rst);
    int n;
    bit pending;
    n = 0;
    do begin
      cycle(rnd_rst && ($urandom_range(0, 149) == 0));
      n++;
      pending = (q0.size() > 0) || (q1.size() > 0) || busy[0] || busy[1] || g_active;
    end while (pending && n < maxc);
    chk("drain", 32'(pending), 32'd0);
    cycle(1'b0);
  endtask

  initial begin
    tx_t x;
    int  k;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; mask0 = '0; mask1 = '0;
    for (int i = 0; i < 256; i++) mm[i] = 8'h00;
    for (int p = 0; p < 2; p++) begin
      busy[p] = 0; wait_cnt[p] = 0; present_cyc[p] = 0; last_lat[p] = 0;
      exp_rd[p] = '0; rd_known[p] = 1'b1; err_cnt[p] = 0;
      cur[p] = mk(1'b0, '0, '0, 4'b0000);
    end
    t = 0; g_active = 0; g_cycle = 0; g_port = 0; free_at = 0; last = 1;
    g_tx = mk(1'b0, '0, '0, 4'b0000); g_err = 0; rst_prev = 1'b1;
    ce_cnt = 0; last_wm = '0; last_rm = '0;

    // Single store then load on port 0
    q0.push_back(mk(1'b1, 32'h10, 32'h12345678, 4'b1111));
    run_until_idle(50, 1'b0);
    chk("st_latency", last_lat[0], 32'd2);
    q0.push_back(mk(1'b0, 32'h10, 32'h0, 4'b1111));
    run_until_idle(50, 1'b0);
    chk("ld_latency", last_lat[0], 32'd2);
    chk("ld_rdata0", rdata0, 32'h12345678);
    chk("ld_err0_cnt", err_cnt[0], 32'd0);

    // Tie from reset: both ports, three loads each
    cycle(1'b1);
    ack_order.delete(); ack_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(1'b0, 32'h10, 32'h0, 4'b1111));
      q1.push_back(mk(1'b0, 32'h14, 32'h0, 4'b1111));
    end
    run_until_idle(100, 1'b0);
    chk("tie_count", ack_order.size(), 32'd6);
    for (int i = 0; i < ack_order.size() && i < 6; i++) chk("tie_order", ack_order[i], i % 2);
    for (int i = 1; i < ack_cyc.size(); i++) chk("tie_gap", ack_cyc[i] - ack_cyc[i-1], 32'd3);

    // Sub-word paths on port 1
    q1.push_back(mk(1'b1, 32'h20, 32'h0, 4'b1111));
    q1.push_back(mk(1'b1, 32'h20, 32'h123456AB, 4'b0001));
    run_until_idle(50, 1'b0);
    chk("byte_wmask", last_wm, 4'b0001);
    q1.push_back(mk(1'b0, 32'h20, 32'h0, 4'b0011));
    run_until_idle(50, 1'b0);
    chk("half_rmask", last_rm, 4'b0011);
    chk("half_rdata1", rdata1, 32'h000000AB);

    // Misaligned accesses on port 0
    ce_cnt = 0; err_cnt[0] = 0;
    q0.push_back(mk(1'b0, 32'h22, 32'h0, 4'b1111));
    q0.push_back(mk(1'b1, 32'h21, 32'h0000FFFF, 4'b0011));
    q0.push_back(mk(1'b0, 32'h41, 32'h0, 4'b0100));
    run_until_idle(80, 1'b0);
    chk("mis_err_cnt", err_cnt[0], 32'd3);
    chk("mis_ce_cnt", ce_cnt, 32'd0);
    q0.push_back(mk(1'b0, 32'h20, 32'h0, 4'b1111));
    run_until_idle(50, 1'b0);
    chk("mis_unchanged", rdata0, 32'h000000AB);

    // Held request: same payload re-presented straight after each ack
    ce_cnt = 0; ack_cyc.delete();
    for (int i = 0; i < 3; i++) q1.push_back(mk(1'b0, 32'h10, 32'h0, 4'b1111));
    run_until_idle(80, 1'b0);
    chk("held_ce_cnt", ce_cnt, 32'd3);
    for (int i = 1; i < ack_cyc.size(); i++) chk("held_gap", ack_cyc[i] - ack_cyc[i-1], 32'd3);
    chk("held_rdata1", rdata1, 32'h12345678);

    // Reset landing on the ACCESS cycle of a store
    q0.push_back(mk(1'b1, 32'h30, 32'h11111111, 4'b1111));
    run_until_idle(50, 1'b0);
    ack_order.delete();
    q0.push_back(mk(1'b1, 32'h30, 32'hDEADBEEF, 4'b1111));
    k = 0;
    do begin cycle(1'b0); k++; end while (!g_active && k < 10);
    chk("rst_grant_seen", 32'(g_active), 32'd1);
    cycle(1'b1);
    cycle(1'b0);
    cycle(1'b0);
    chk("rst_no_ack", ack_order.size(), 32'd0);
    q0.push_back(mk(1'b0, 32'h30, 32'h0, 4'b1111));
    run_until_idle(50, 1'b0);
    chk("rst_old_value", rdata0, 32'h11111111);

    // Random traffic on both ports with occasional reset pulses
    for (int i = 0; i < 40; i++) begin
      x = rand_tx(); q0.push_back(x);
      x = rand_tx(); q1.push_back(x);
    end
    run_until_idle(5000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
